fetch_trigger_responder: RTL
============================

# fetch_trigger_responder

Consumes the seven-phase fetch trigger sequence and the mux/demux controls from the fetch sequencer, and does the fetch work those triggers request. It holds the program counter, drives a synchronous program-memory read port, and assembles two memory bytes into one instruction word. It also checks that the triggers arrive in the correct order, raising a sticky error and resynchronising when they do not. It sits between the fetch sequencer and program memory, feeding the decode stage.

## Interface
- ADDR_W, 8, program-memory address width; PC width
- DATA_W, 8, program-memory data width; instruction is 2*DATA_W
- RESET_PC, 0, address of first instruction after reset
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- latch_trigger, update_pc_trigger, fetch_prog_mem1_trigger, decode_instr1_trigger, fetch_prog_mem2_trigger, decode_instr2_trigger, out_latch_trigger  in  1 each  phase triggers, sequence order as listed
- mem_mux_control  in  1  sequencer mux control (checked)
- demux_control  in  1  sequencer demux control (checked)
- pc_load  in  1  branch request, sampled at latch phase only
- pc_load_value  in  ADDR_W  branch target
- err_clear  in  1  clears seq_error
- mem_addr  out  ADDR_W  program-memory read address (combinational)
- mem_rd_en  out  1  program-memory read strobe (combinational)
- mem_rd_data  in  DATA_W  memory data, valid the cycle after mem_rd_en
- instr  out  2*DATA_W  assembled instruction {first byte, second byte}
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  one-cycle pulse per completed instruction
- pc  out  ADDR_W  current fetch address
- seq_error  out  1  sticky protocol error
- seq_state  out  3  current expected-phase index 0..6

## Operation
- FSM states: W_LATCH(0), W_UPD(1), W_F1(2), W_D1(3), W_F2(4), W_D2(5), W_OUT(6). Each state waits for its phase trigger, in the order listed above.
- Each cycle is classified as one of:
  - idle: no trigger high.
  - legal: exactly the expected trigger high, and mux/demux controls at their expected values. mem_mux_control is expected 1 in W_D1 and W_F2, 0 otherwise. demux_control is expected 1 in W_D2 and W_OUT, 0 otherwise.
  - illegal: anything else.
- idle: state holds, no action.
- legal: the phase action executes and the state advances; W_OUT wraps to W_LATCH.
- illegal: seq_error is set and no phase action executes. Resync rule: if latch_trigger alone is high with controls 0, the latch action executes and the next state is W_UPD; otherwise the next state is W_LATCH.
- Phase actions:
  - latch: capture pc_load into pend_load and pc_load_value into pend_val.
  - update_pc: if pend_load, pc <= pend_val. Else if the started flag is set, pc <= pc+2. Else (first instruction after reset) pc holds. Then set started and clear pend_load.
  - fetch1: mem_rd_en=1, mem_addr=pc in the same cycle.
  - decode1: instr_hi <= mem_rd_data.
  - fetch2: mem_rd_en=1, mem_addr=pc+1.
  - decode2: instr_lo <= mem_rd_data.
  - out_latch: instr <= {instr_hi, instr_lo}, instr_pc <= pc, instr_valid pulses.
- Outside legal fetch phases, mem_rd_en=0 and mem_addr=pc.
- Arithmetic: pc+1 and pc+2 are modulo 2^ADDR_W; 0xFF+2 = 0x01 and 0xFF+1 = 0x00 at ADDR_W=8.
- err_clear clears seq_error; a same-cycle illegal event wins, so seq_error stays 1.

## Timing
- Reset values (asynchronous):
  - state W_LATCH
  - pc = RESET_PC
  - started = 0, pend_load = 0, pend_val = 0
  - instr_hi, instr_lo, instr, instr_pc = 0
  - instr_valid = 0, seq_error = 0
  - mem_rd_en = 0
- Trigger sampled at edge k: the registered effect is visible after edge k. mem_rd_en and mem_addr are combinational, asserted during the trigger cycle itself.
- Memory samples the address at the same edge as fetch; data is captured at the next edge by the decode trigger.
- instr_valid is high for the one cycle after the edge sampling out_latch_trigger.
- With back-to-back sequences, latency from latch_trigger to instr_valid is 7 cycles, giving one instruction per 7 cycles.
- seq_error rises the cycle after the illegal edge.
- Reset mid-sequence discards the partial instruction; no instr_valid is produced for it.

## Test plan
- Reset, RESET_PC=0x10, seven legal phases, memory[0x10]=0xA5, [0x11]=0x3C -> instr=0xA53C, instr_pc=0x10, instr_valid one cycle, seq_error=0.
- Second sequence continues the first -> mem_addr 0x12 then 0x13, instr_pc=0x12.
- pc_load=1, pc_load_value=0xFF at latch -> fetch addresses 0xFF then 0x00; the following sequence fetches from 0x01.
- fetch_prog_mem2_trigger while in W_F1 -> no mem_rd_en, seq_error=1, state=0. Then a legal full sequence -> instr_valid; err_clear -> seq_error=0.
- mem_mux_control=0 during decode1 -> seq_error=1, instr_hi unchanged. Also: two triggers high at once -> seq_error=1.
- Assert reset during W_D2 -> all outputs return to reset values immediately, with no instr_valid. After release, a legal sequence fetches RESET_PC.

Source files
------------

// File: rtl/fetch_trigger_responder.sv
// Fetch-side responder to the seven-phase fetch trigger sequence: owns the PC,
// drives the program-memory read port, assembles instructions and polices phase order.
module fetch_trigger_responder #(
  parameter int unsigned           ADDR_W   = 8,
  parameter int unsigned           DATA_W   = 8,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  latch_trigger,
  input  logic                  update_pc_trigger,
  input  logic                  fetch_prog_mem1_trigger,
  input  logic                  decode_instr1_trigger,
  input  logic                  fetch_prog_mem2_trigger,
  input  logic                  decode_instr2_trigger,
  input  logic                  out_latch_trigger,
  input  logic                  mem_mux_control,
  input  logic                  demux_control,
  input  logic                  pc_load,
  input  logic [ADDR_W-1:0]     pc_load_value,
  input  logic                  err_clear,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic [2*DATA_W-1:0]   instr,
  output logic [ADDR_W-1:0]     instr_pc,
  output logic                  instr_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic                  seq_error,
  output logic [2:0]            seq_state
);

  typedef enum logic [2:0] {
    W_LATCH = 3'd0,
    W_UPD   = 3'd1,
    W_F1    = 3'd2,
    W_D1    = 3'd3,
    W_F2    = 3'd4,
    W_D2    = 3'd5,
    W_OUT   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

  state_t               r_state, w_next_state;
  logic [ADDR_W-1:0]    r_pc;
  logic                 r_started;
  logic                 r_pend_load;
  logic [ADDR_W-1:0]    r_pend_val;
  logic [DATA_W-1:0]    r_instr_hi;
  logic [DATA_W-1:0]    r_instr_lo;
  logic [2*DATA_W-1:0]  r_instr;
  logic [ADDR_W-1:0]    r_instr_pc;
  logic                 r_instr_valid;
  logic                 r_seq_error;

  logic [6:0]           w_trig;
  logic [6:0]           w_expected_trig;
  logic                 w_exp_mux;
  logic                 w_exp_demux;
  logic                 w_any_trig;
  logic                 w_legal;
  logic                 w_illegal;
  logic                 w_resync;
  logic                 w_do_latch;

  assign w_trig = {out_latch_trigger, decode_instr2_trigger, fetch_prog_mem2_trigger,
                   decode_instr1_trigger, fetch_prog_mem1_trigger, update_pc_trigger,
                   latch_trigger};

  assign w_expected_trig = 7'b000_0001 << r_state;
  assign w_exp_mux       = (r_state == W_D1) || (r_state == W_F2);
  assign w_exp_demux     = (r_state == W_D2) || (r_state == W_OUT);
  assign w_any_trig      = |w_trig;
  assign w_legal         = (w_trig == w_expected_trig) &&
                           (mem_mux_control == w_exp_mux) &&
                           (demux_control == w_exp_demux);
  assign w_illegal       = w_any_trig && !w_legal;
  // A lone, clean latch trigger out of order still starts a fresh sequence.
  assign w_resync        = w_illegal && (w_trig == 7'b000_0001) &&
                           !mem_mux_control && !demux_control;
  assign w_do_latch      = (w_legal && (r_state == W_LATCH)) || w_resync;

  always_comb begin
    w_next_state = r_state;
    if (w_legal) begin
      w_next_state = (r_state == W_OUT) ? W_LATCH : state_t'(r_state + 3'd1);
    end else if (w_illegal) begin
      w_next_state = w_resync ? W_UPD : W_LATCH;
    end
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = r_pc;
    if (w_legal && (r_state == W_F1)) begin
      mem_rd_en = 1'b1;
    end else if (w_legal && (r_state == W_F2)) begin
      mem_rd_en = 1'b1;
      mem_addr  = r_pc + PC_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= W_LATCH;
      r_pc          <= RESET_PC;
      r_started     <= 1'b0;
      r_pend_load   <= 1'b0;
      r_pend_val    <= '0;
      r_instr_hi    <= '0;
      r_instr_lo    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_seq_error   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_instr_valid <= w_legal && (r_state == W_OUT);

      if (w_illegal) begin
        r_seq_error <= 1'b1;
      end else if (err_clear) begin
        r_seq_error <= 1'b0;
      end

      if (w_do_latch) begin
        r_pend_load <= pc_load;
        r_pend_val  <= pc_load_value;
      end

      if (w_legal) begin
        unique case (r_state)
          W_UPD: begin
            if (r_pend_load) begin
              r_pc <= r_pend_val;
            end else if (r_started) begin
              r_pc <= r_pc + PC_TWO;
            end
            r_started   <= 1'b1;
            r_pend_load <= 1'b0;
          end
          W_D1:  r_instr_hi <= mem_rd_data;
          W_D2:  r_instr_lo <= mem_rd_data;
          W_OUT: begin
            r_instr    <= {r_instr_hi, r_instr_lo};
            r_instr_pc <= r_pc;
          end
          default: ;
        endcase
      end
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign seq_error   = r_seq_error;
  assign seq_state   = r_state;

endmodule
